// File: rtl/mult_div_pkg.sv
// mult_div_pkg: op encoding, FSM states and shared constants for the multiply/divide unit
package mult_div_pkg;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam int ITERATIONS = 32;
  localparam logic [31:0] DIV_ZERO_EXP = 32'd255;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one unsigned restoring-division step (shift in a dividend bit, trial subtract)
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff = w_shift - {1'b0, i_div};
    o_q = ~w_diff[WIDTH];
    o_rem = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply (radix-2 Booth) and divide (restoring) producing HI/LO
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(ITERATIONS);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_b, r_hi, r_lo;
  logic r_q1, r_op, r_neg_q, r_neg_r, r_busy, r_done, r_dz;
  logic [WIDTH:0] w_sum;
  logic [WIDTH-1:0] w_rem, w_div_q, w_a_mag, w_b_mag, w_res_hi, w_res_lo;
  logic w_qbit;
  assign w_a_mag = a[WIDTH-1] ? -a : a;
  assign w_b_mag = b[WIDTH-1] ? -b : b;
  // Booth step on a sign-extended accumulator so -2^(W-1) operands cannot overflow
  assign w_sum = (r_q[0] == r_q1) ? {r_acc[WIDTH-1], r_acc} :
                 r_q[0] ? {r_acc[WIDTH-1], r_acc} - {r_b[WIDTH-1], r_b} :
                          {r_acc[WIDTH-1], r_acc} + {r_b[WIDTH-1], r_b};
  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .i_rem(r_acc),
    .i_bit(r_q[WIDTH-1]),
    .i_div(r_b),
    .o_rem(w_rem),
    .o_q  (w_qbit)
  );
  assign w_div_q = {r_q[WIDTH-2:0], w_qbit};
  assign w_res_hi = (r_op == OP_DIV) ? (r_neg_r ? -w_rem : w_rem) : w_sum[WIDTH:1];
  assign w_res_lo = (r_op == OP_DIV) ? (r_neg_q ? -w_div_q : w_div_q) : {w_sum[0], r_q[WIDTH-1:1]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_acc <= '0;
      r_q <= '0;
      r_q1 <= 1'b0;
      r_b <= '0;
      r_op <= OP_MULT;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi <= '0;
      r_lo <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_cnt <= '0;
          r_acc <= '0;
          r_q1 <= 1'b0;
          r_op <= op;
          r_q <= (op == OP_DIV) ? w_a_mag : a;
          r_b <= (op == OP_DIV) ? w_b_mag : b;
          r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
          r_neg_r <= a[WIDTH-1];
          r_busy <= 1'b1;
          if (op == OP_DIV && b == '0) begin
            r_state <= DONE;
            r_done <= 1'b1;
            r_dz <= 1'b1;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= (r_op == OP_DIV) ? w_rem : w_sum[WIDTH:1];
          r_q <= (r_op == OP_DIV) ? w_div_q : {w_sum[0], r_q[WIDTH-1:1]};
          r_q1 <= r_q[0];
          if (r_cnt == CW'(ITERATIONS - 1)) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
            r_done <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done <= 1'b0;
          r_dz <= 1'b0;
          r_busy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign hi = r_hi;
  assign lo = r_lo;
  assign busy = r_busy;
  assign done = r_done;
  assign div_zero = r_dz;
endmodule
